// File: rtl/backbone_seq_ctrl.sv
// Backbone row sequencer: starts the index generator once per backbone row,
// pops the backbone FIFO between rows after a fixed idle gap, tracks beats
// still in flight through the divider, and reports when a frame has drained.
module backbone_seq_ctrl #(
  parameter  int J       = 14,
  parameter  int GAP     = 4,
  parameter  int OWIDTH  = 8,
  localparam int J_WIDTH = $clog2(J) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               first_backbone,
  input  logic               fifo_empty,
  input  logic               gen_tvalid,
  input  logic               gen_tlast,
  input  logic               gen_idle,
  input  logic               vinput_tvalid,
  input  logic               abort,
  output logic               start_gen,
  output logic               fifo_request,
  output logic [J_WIDTH-1:0] ind_j,
  output logic               busy,
  output logic               frame_done,
  output logic               err
);

  localparam int GW = $clog2(GAP) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_WAIT,
    S_GAPC,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [J_WIDTH-1:0]  ind_j_q, ind_j_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [OWIDTH-1:0]   out_q, out_d;
  logic                start_gen_q, start_gen_d;
  logic                fifo_request_q, fifo_request_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                err_q, err_d;
  logic                inc, dec;

  // Net change of the in-flight count: a simultaneous issue and retire cancel.
  assign inc = gen_tvalid && !vinput_tvalid;
  assign dec = vinput_tvalid && !gen_tvalid;

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d        = state_q;
    ind_j_d        = ind_j_q;
    gap_d          = gap_q;
    out_d          = out_q;
    err_d          = err_q;
    start_gen_d    = 1'b0;
    fifo_request_d = 1'b0;
    frame_done_d   = 1'b0;

    // In-flight beats are tracked in every state; over/underflow saturates.
    if (inc) begin
      if (out_q == '1) err_d = 1'b1;
      else             out_d = out_q + OWIDTH'(1);
    end else if (dec) begin
      if (out_q == '0) err_d = 1'b1;
      else             out_d = out_q - OWIDTH'(1);
    end

    // Protocol violations are flagged and otherwise have no effect.
    if (first_backbone && state_q != S_IDLE) err_d = 1'b1;
    if (gen_tlast && state_q != S_GEN)       err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (first_backbone) begin
          state_d     = S_GEN;
          ind_j_d     = '0;
          start_gen_d = 1'b1;
        end
      end
      S_GEN: begin
        // A tlast only ends the row once the generator has really gone idle.
        if (gen_tlast && gen_idle) begin
          if (ind_j_q == J_WIDTH'(J - 1)) begin
            state_d = S_DRAIN;
          end else if (!fifo_empty) begin
            state_d = S_GAPC;
            gap_d   = GW'(GAP - 1);
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!fifo_empty) begin
          state_d = S_GAPC;
          gap_d   = GW'(GAP - 1);
        end
      end
      S_GAPC: begin
        if (gap_q == '0) begin
          state_d        = S_FETCH;
          fifo_request_d = 1'b1;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      S_FETCH: begin
        // Only reachable below the last row, so ind_j cannot pass J-1.
        state_d     = S_GEN;
        ind_j_d     = ind_j_q + J_WIDTH'(1);
        start_gen_d = 1'b1;
      end
      S_DRAIN: begin
        // Look at this cycle's updated count so the pulse follows the
        // final retire by exactly one cycle.
        if (out_d == '0) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Soft clear outranks everything, including a same-cycle frame start.
    if (abort) begin
      state_d        = S_IDLE;
      ind_j_d        = '0;
      gap_d          = '0;
      out_d          = '0;
      err_d          = 1'b0;
      start_gen_d    = 1'b0;
      fifo_request_d = 1'b0;
      frame_done_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ind_j_q        <= '0;
      gap_q          <= '0;
      out_q          <= '0;
      start_gen_q    <= 1'b0;
      fifo_request_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      ind_j_q        <= ind_j_d;
      gap_q          <= gap_d;
      out_q          <= out_d;
      start_gen_q    <= start_gen_d;
      fifo_request_q <= fifo_request_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      err_q          <= err_d;
    end
  end

  assign start_gen    = start_gen_q;
  assign fifo_request = fifo_request_q;
  assign ind_j        = ind_j_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_backbone_seq_ctrl.sv
// Bench for backbone_seq_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a deadline-based reference model.
module tb_backbone_seq_ctrl;
  localparam int J    = 3;
  localparam int GAP  = 4;
  localparam int OW   = 3;
  localparam int JW   = $clog2(J) + 1;
  localparam int OMAX = (1 << OW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic first_backbone = 1'b0, fifo_empty = 1'b0, gen_tvalid = 1'b0;
  logic gen_tlast = 1'b0, gen_idle = 1'b0, vinput_tvalid = 1'b0, abort = 1'b0;
  logic start_gen, fifo_request, busy, frame_done, err;
  logic [JW-1:0] ind_j;

  always #5 clk = ~clk;

  backbone_seq_ctrl #(.J(J), .GAP(GAP), .OWIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .first_backbone(first_backbone),
    .fifo_empty(fifo_empty), .gen_tvalid(gen_tvalid), .gen_tlast(gen_tlast),
    .gen_idle(gen_idle), .vinput_tvalid(vinput_tvalid), .abort(abort),
    .start_gen(start_gen), .fifo_request(fifo_request), .ind_j(ind_j),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  int tests = 0, fails = 0, cyc = 0;
  int last_req, last_start, last_done, t_tl, t_fall, last_gv;
  bit fe_g = 1'b0, sched_en = 1'b0;
  bit vin_at [8192];

  // Reference model: frame phase plus absolute deadline for the FIFO pop.
  typedef enum {PH_IDLE, PH_ROW, PH_STARVED, PH_COUNTDOWN, PH_POPPED, PH_DRAINING} ph_t;
  ph_t ph = PH_IDLE;
  int  m_row = 0, m_out = 0, due = 0;
  bit  m_err = 0, e_start = 0, e_freq = 0, e_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    ph = PH_IDLE; m_row = 0; m_out = 0; m_err = 0;
    e_start = 0; e_freq = 0; e_done = 0;
  endtask

  task automatic model_edge(input bit fb, fe, gv, tl, gi, vv, ab);
    e_start = 0; e_freq = 0; e_done = 0;
    if (ab) begin
      ph = PH_IDLE; m_row = 0; m_out = 0; m_err = 0;
      return;
    end
    if (gv && !vv) begin
      if (m_out == OMAX) m_err = 1; else m_out = m_out + 1;
    end else if (vv && !gv) begin
      if (m_out == 0) m_err = 1; else m_out = m_out - 1;
    end
    if (fb && ph != PH_IDLE) m_err = 1;
    if (tl && ph != PH_ROW) m_err = 1;
    case (ph)
      PH_IDLE: if (fb) begin ph = PH_ROW; m_row = 0; e_start = 1; end
      PH_ROW: if (tl && gi) begin
        if (m_row == J - 1) ph = PH_DRAINING;
        else if (!fe) begin ph = PH_COUNTDOWN; due = cyc + GAP + 1; end
        else ph = PH_STARVED;
      end
      PH_STARVED: if (!fe) begin ph = PH_COUNTDOWN; due = cyc + GAP + 1; end
      PH_COUNTDOWN: if (cyc + 1 == due) begin e_freq = 1; ph = PH_POPPED; end
      PH_POPPED: begin ph = PH_ROW; m_row = m_row + 1; e_start = 1; end
      PH_DRAINING: if (m_out == 0) begin e_done = 1; ph = PH_IDLE; end
      default: ph = PH_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("start_gen", start_gen, e_start);
    chk("fifo_request", fifo_request, e_freq);
    chk("frame_done", frame_done, e_done);
    chk("ind_j", ind_j, m_row);
    chk("busy", busy, ph != PH_IDLE);
    chk("err", err, m_err);
    chk("start_req_excl", start_gen & fifo_request, 0);
  endtask

  task automatic clr_sched();
    foreach (vin_at[i]) vin_at[i] = 1'b0;
  endtask

  // One clock: drive at negedge, model at posedge, compare 1ns later.
  task automatic tk(input bit fb, gv, tl, gi, ab, input bit vx = 1'b0);
    bit vv;
    @(negedge clk);
    vv = vin_at[cyc] | vx;
    first_backbone = fb; fifo_empty = fe_g; gen_tvalid = gv; gen_tlast = tl;
    gen_idle = gi; vinput_tvalid = vv; abort = ab;
    if (gv && sched_en && cyc + 10 < 8192) vin_at[cyc + 10] = 1'b1;
    @(posedge clk);
    model_edge(fb, fe_g, gv, tl, gi, vv, ab);
    cyc++;
    #1;
    check_all();
    if (start_gen)    last_start = cyc;
    if (fifo_request) last_req   = cyc;
    if (frame_done)   last_done  = cyc;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 40; i++) begin
      tk(0, 0, 0, 0, 0);
      if (start_gen) break;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      tk(0, 0, 0, 0, 0);
      if (frame_done) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst_n is held low.
    #22;
    chk("rst_start_gen", start_gen, 0); chk("rst_fifo_request", fifo_request, 0);
    chk("rst_busy", busy, 0); chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0); chk("rst_ind_j", ind_j, 0);
    clr_sched(); model_reset();

    // Nominal frame; frame start on the very first edge after release.
    @(posedge clk); #2 rst_n = 1'b1;
    sched_en = 1; fe_g = 0;
    tk(1, 0, 0, 0, 0);
    chk("a_first_start", start_gen, 1);
    for (int r = 0; r < J; r++) begin
      chk("a_row_ind_j", ind_j, r);
      tk(0, 1, 0, 0, 0);
      t_tl = cyc; last_gv = cyc;
      last_req = -1000; last_start = -1000;
      tk(0, 1, 1, 1, 0);
      if (r < J - 1) begin
        wait_start();
        chk("a_req_lat", last_req - t_tl, GAP + 1);
        chk("a_start_lat", last_start - t_tl, GAP + 2);
      end
    end
    last_done = -1000;
    wait_done();
    chk("a_done_cycle", last_done, last_gv + 11);
    chk("a_err_clean", err, 0);

    // first_backbone during the gap countdown: flagged, sequence unaffected.
    tk(1, 0, 0, 0, 0);
    tk(0, 1, 0, 0, 0);
    t_tl = cyc; last_req = -1000; last_start = -1000;
    tk(0, 1, 1, 1, 0);
    tk(0, 0, 0, 0, 0); tk(0, 0, 0, 0, 0);
    tk(1, 0, 0, 0, 0);
    chk("b_fb_gapc_err", err, 1);
    wait_start();
    chk("b_req_lat", last_req - t_tl, GAP + 1);
    chk("b_start_lat", last_start - t_tl, GAP + 2);
    chk("b_ind_j", ind_j, 1);
    tk(0, 0, 0, 0, 1);
    clr_sched();
    chk("b_abort_busy", busy, 0); chk("b_abort_err", err, 0);

    // Empty FIFO at tlast, tlast while waiting, then abort in the gap.
    tk(1, 0, 0, 0, 0);
    tk(0, 1, 0, 0, 0);
    fe_g = 1;
    tk(0, 1, 1, 1, 0);
    tk(0, 0, 0, 0, 0); tk(0, 0, 0, 0, 0);
    tk(0, 0, 1, 1, 0);
    chk("c_tlast_wait_err", err, 1);
    chk("c_wait_busy", busy, 1);
    tk(0, 0, 0, 0, 0); tk(0, 0, 0, 0, 0); tk(0, 0, 0, 0, 0);
    fe_g = 0; t_fall = cyc; last_req = -1000; last_start = -1000;
    wait_start();
    chk("c_req_after_fall", last_req - t_fall, GAP + 1);
    chk("c_start_after_fall", last_start - t_fall, GAP + 2);
    tk(0, 1, 0, 0, 0);
    tk(0, 1, 1, 1, 0);
    tk(0, 0, 0, 0, 0); tk(0, 0, 0, 0, 0);
    tk(0, 0, 0, 0, 1);
    clr_sched();
    chk("c_abort_busy", busy, 0); chk("c_abort_ind_j", ind_j, 0);
    chk("c_abort_err", err, 0);
    last_req = -1000;
    repeat (10) tk(0, 0, 0, 0, 0);
    chk("c_no_req_after_abort", last_req, -1000);

    // Outstanding counter: cancel, underflow (sticky), overflow.
    sched_en = 0;
    repeat (3) tk(0, 1, 0, 0, 0);
    tk(0, 1, 0, 0, 0, 1);
    repeat (3) tk(0, 0, 0, 0, 0, 1);
    chk("d_balanced_no_err", err, 0);
    tk(0, 0, 0, 0, 0, 1);
    chk("d_underflow_err", err, 1);
    repeat (5) tk(0, 0, 0, 0, 0);
    chk("d_err_sticky", err, 1);
    tk(0, 0, 0, 0, 1);
    chk("d_abort_clears_err", err, 0);
    repeat (OMAX) tk(0, 1, 0, 0, 0);
    chk("d_full_no_err", err, 0);
    tk(0, 1, 0, 0, 0);
    chk("d_overflow_err", err, 1);
    tk(0, 0, 0, 0, 1);

    // Reset while draining: outputs clear at once, no frame_done later.
    tk(1, 0, 0, 0, 0);
    for (int r = 0; r < J; r++) begin
      tk(0, 1, 0, 0, 0);
      tk(0, 1, 1, 1, 0);
      if (r < J - 1) wait_start();
    end
    repeat (3) tk(0, 0, 0, 0, 0);
    chk("e_drain_busy", busy, 1);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("e_rst_start_gen", start_gen, 0); chk("e_rst_fifo_request", fifo_request, 0);
    chk("e_rst_busy", busy, 0); chk("e_rst_frame_done", frame_done, 0);
    chk("e_rst_err", err, 0); chk("e_rst_ind_j", ind_j, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    last_done = -1000;
    repeat (10) tk(0, 0, 0, 0, 0);
    chk("e_no_done_after_rst", last_done, -1000);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit fb, gv, tl, gi, ab, vv;
      fe_g = ($urandom_range(0, 9) < 3);
      fb = (ph == PH_IDLE) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) < 1);
      gv = (ph == PH_ROW) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 5);
      tl = (ph == PH_ROW) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 99) < 2);
      gi = ($urandom_range(0, 9) < 8);
      vv = (m_out > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 3);
      ab = ($urandom_range(0, 99) < 2);
      tk(fb, gv, tl, gi, ab, vv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
